// File: rtl/gbuff_dma_if.sv
// Command, write-stream, read-stream and SRAM signals of the global-buffer DMA.
// slave is the DMA's view; master is the datapath/SRAM side.
interface gbuff_dma_if #(
    parameter int WORD_SIZE = 128,
    parameter int ADDR_BITS = 10,
    parameter int LEN_BITS  = 11
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic                 cmd_dir;
    logic [ADDR_BITS-1:0] cmd_addr;
    logic [LEN_BITS-1:0]  cmd_len;
    logic [WORD_SIZE-1:0] wr_data;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [WORD_SIZE-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;
    logic                 sram_wen;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [WORD_SIZE-1:0] sram_di;
    logic [WORD_SIZE-1:0] sram_do;
    logic                 busy;
    logic                 done;

    modport slave (
        input  cmd_valid, cmd_dir, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, sram_do,
        output cmd_ready, wr_ready, rd_data, rd_valid, sram_wen, sram_addr, sram_di, busy, done
    );

    modport master (
        output cmd_valid, cmd_dir, cmd_addr, cmd_len, wr_data, wr_valid, rd_ready, sram_do,
        input  cmd_ready, wr_ready, rd_data, rd_valid, sram_wen, sram_addr, sram_di, busy, done
    );
endinterface

// File: rtl/gbuff_dma.sv
// Single-command DMA initiator for the global-buffer SRAM: streams words into it or
// out of it through a 3-entry output FIFO fed by a 2-stage read pipeline.
module gbuff_dma #(
    parameter int WORD_SIZE = 128,
    parameter int ADDR_BITS = 10,
    parameter int LEN_BITS  = 11
) (
    input  logic        clk,
    input  logic        reset,
    gbuff_dma_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WRITE, READ, FIN} state_t;

    state_t               state, state_nxt;
    logic [LEN_BITS-1:0]  len_q, xfer_cnt, issued, xfer_inc;
    logic [ADDR_BITS-1:0] cur, issue_addr;
    logic                 sram_wen;
    logic [ADDR_BITS-1:0] sram_addr;
    logic [WORD_SIZE-1:0] sram_di;
    logic                 pend_addr, pend_data;
    logic [WORD_SIZE-1:0] fifo_mem [3];
    logic [1:0]           wp, rp, fcnt;
    logic [2:0]           outstanding;
    logic                 accept, start_rd, wr_hs, rd_hs, last_xfer, issue, push, pop;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign bus.cmd_ready = (state == IDLE) & ~reset;
    assign bus.wr_ready  = (state == WRITE);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == FIN);
    assign bus.rd_valid  = (fcnt != 2'd0);
    assign bus.rd_data   = fifo_mem[rp];
    assign bus.sram_wen  = sram_wen;
    assign bus.sram_addr = sram_addr;
    assign bus.sram_di   = sram_di;

    assign accept    = bus.cmd_valid & bus.cmd_ready;
    assign start_rd  = accept & bus.cmd_dir & (bus.cmd_len != '0);
    assign wr_hs     = (state == WRITE) & bus.wr_valid;
    assign rd_hs     = bus.rd_valid & bus.rd_ready;
    assign xfer_inc  = xfer_cnt + 1'b1;
    assign last_xfer = (xfer_inc == len_q);
    // Reads in the address stage and on sram_do each hold a FIFO slot in reserve.
    assign outstanding = {1'b0, fcnt} + {2'b0, pend_addr} + {2'b0, pend_data};
    // The first read goes out on the accept edge so data is visible three cycles later.
    assign issue      = start_rd | ((state == READ) & (outstanding < 3'd3) & (issued < len_q));
    assign issue_addr = start_rd ? bus.cmd_addr : cur;
    assign push       = pend_data;
    assign pop        = rd_hs;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (accept) begin
                       if (bus.cmd_len == '0) state_nxt = FIN;
                       else if (bus.cmd_dir)  state_nxt = READ;
                       else                   state_nxt = WRITE;
                   end
            WRITE: if (wr_hs & last_xfer) state_nxt = FIN;
            READ:  if (rd_hs & last_xfer) state_nxt = FIN;
            FIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sram_wen  <= 1'b0;
            sram_addr <= '0;
            sram_di   <= '0;
            cur       <= '0;
            len_q     <= '0;
            xfer_cnt  <= '0;
            issued    <= '0;
            pend_addr <= 1'b0;
            pend_data <= 1'b0;
            wp        <= 2'd0;
            rp        <= 2'd0;
            fcnt      <= 2'd0;
        end else begin
            sram_wen <= wr_hs;
            if (accept) begin
                len_q    <= bus.cmd_len;
                xfer_cnt <= '0;
                issued   <= '0;
                cur      <= bus.cmd_addr;
            end
            if (wr_hs | rd_hs) xfer_cnt <= xfer_inc;
            if (wr_hs) begin
                sram_addr <= cur;
                sram_di   <= bus.wr_data;
                cur       <= cur + 1'b1;
            end
            if (issue) begin
                sram_addr <= issue_addr;
                cur       <= issue_addr + 1'b1;
                issued    <= start_rd ? LEN_BITS'(1) : issued + 1'b1;
            end
            pend_addr <= issue;
            pend_data <= pend_addr;
            if (push) wp <= nxt(wp);
            if (pop)  rp <= nxt(rp);
            fcnt <= fcnt + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wp] <= bus.sram_do;
    end
endmodule
